// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority vote,
// parity/framing/break/overrun detection and a valid/ready holding register.
module uart_rx_cfg #(
    parameter int CLK_FREQ_HZ = 48_000_000,
    parameter int BAUDRATE    = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Framing_Err,
    output logic                 o_Overrun,
    output logic                 o_Break,
    output logic                 o_Busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int HALF         = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_cpb_chk
            $error("uart_rx_cfg: CLKS_PER_BIT must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
            $error("uart_rx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_par_chk
            $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    function automatic logic majority3(input logic [2:0] h);
        majority3 = (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    // Odd mode wants the XOR of data and parity bit to be 1, even mode wants 0.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        parity_bad = ((^d) ^ p) != (PARITY == 1);
    endfunction

    state_t               state_r, state_nxt_s;
    logic [1:0]           sync_r;
    logic [2:0]           hist_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [3:0]           bit_cnt_r;
    logic                 stop_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 par_err_r;
    logic                 frm_err_r;
    logic                 maj_s;
    logic                 bit_tick_s;
    logic                 brk_cond_s;
    logic                 done_s;
    logic                 brk_s;
    logic                 frm_fin_s;

    assign maj_s      = majority3(hist_r);
    assign bit_tick_s = (cnt_r == CNT_LAST);
    assign brk_cond_s = (stop_cnt_r == 1'b0) && !maj_s && (shift_r == {DATA_BITS{1'b0}})
                        && ((PARITY == 0) || !par_bit_r);
    assign frm_fin_s  = frm_err_r | ~maj_s;
    assign o_Busy     = (state_r != S_IDLE);

    // Synchroniser and majority-vote sample history, idle-high after reset.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync_r <= 2'b11;
            hist_r <= 3'b111;
        end else begin
            sync_r <= {sync_r[0], i_Rx_Serial};
            hist_r <= {hist_r[1:0], sync_r[1]};
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus completion and break strobes.
    always_comb begin
        state_nxt_s = state_r;
        done_s      = 1'b0;
        brk_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!sync_r[1]) state_nxt_s = S_START;
                else            state_nxt_s = S_IDLE;
            end
            S_START: begin
                if (cnt_r == CNT_HALF) state_nxt_s = maj_s ? S_IDLE : S_DATA;
                else                   state_nxt_s = S_START;
            end
            S_DATA: begin
                if (bit_tick_s && bit_cnt_r == BIT_LAST)
                    state_nxt_s = (PARITY != 0) ? S_PARITY : S_STOP;
                else
                    state_nxt_s = S_DATA;
            end
            S_PARITY: begin
                if (bit_tick_s) state_nxt_s = S_STOP;
                else            state_nxt_s = S_PARITY;
            end
            S_STOP: begin
                if (bit_tick_s && brk_cond_s) begin
                    state_nxt_s = S_BRK_WAIT;
                    brk_s       = 1'b1;
                end else if (bit_tick_s && stop_cnt_r == STOP_LAST) begin
                    state_nxt_s = S_IDLE;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = S_STOP;
                end
            end
            S_BRK_WAIT: begin
                if (maj_s) state_nxt_s = S_IDLE;
                else       state_nxt_s = S_BRK_WAIT;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Bit-period counter, data shifter and pending error flags.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            stop_cnt_r <= 1'b0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_bit_r  <= 1'b0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
        end else begin
            if (state_r == S_IDLE || state_r == S_BRK_WAIT || state_nxt_s != state_r || bit_tick_s)
                cnt_r <= {CNT_W{1'b0}};
            else
                cnt_r <= cnt_r + CNT_W'(1);

            if (state_r == S_IDLE && state_nxt_s == S_START) begin
                bit_cnt_r  <= 4'd0;
                stop_cnt_r <= 1'b0;
                shift_r    <= {DATA_BITS{1'b0}};
                par_bit_r  <= 1'b0;
                par_err_r  <= 1'b0;
                frm_err_r  <= 1'b0;
            end else if (bit_tick_s) begin
                case (state_r)
                    S_DATA: begin
                        shift_r   <= {maj_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                    S_PARITY: begin
                        par_bit_r <= maj_s;
                        par_err_r <= parity_bad(shift_r, maj_s);
                    end
                    S_STOP: begin
                        if (!maj_s) frm_err_r <= 1'b1;
                        stop_cnt_r <= stop_cnt_r + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Holding register: deliver, drop with overrun, or release on accept.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Rx_DV       <= 1'b0;
            o_Rx_Data     <= {DATA_BITS{1'b0}};
            o_Parity_Err  <= 1'b0;
            o_Framing_Err <= 1'b0;
            o_Overrun     <= 1'b0;
            o_Break       <= 1'b0;
        end else begin
            o_Overrun <= 1'b0;
            o_Break   <= brk_s;
            if (done_s) begin
                if (!o_Rx_DV || i_Rx_Ready) begin
                    o_Rx_DV       <= 1'b1;
                    o_Rx_Data     <= shift_r;
                    o_Parity_Err  <= par_err_r;
                    o_Framing_Err <= frm_fin_s;
                end else begin
                    o_Overrun <= 1'b1;
                end
            end else if (o_Rx_DV && i_Rx_Ready) begin
                o_Rx_DV <= 1'b0;
            end else begin
                o_Rx_DV <= o_Rx_DV;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances cover 8N1 defaults,
// even parity, and 7-data/2-stop framing.
module tb_uart_rx_cfg;
    localparam int CPA = 416;
    localparam int CPS = 16;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rx_a  = 1'b1;
    logic rx_b  = 1'b1;
    logic rx_c  = 1'b1;
    logic rdy_a = 1'b1;

    logic       dv_a, perr_a, ferr_a, ovr_a, brk_a, busy_a;
    logic [7:0] data_a;
    logic       dv_b, perr_b, ferr_b, ovr_b, brk_b, busy_b;
    logic [7:0] data_b;
    logic       dv_c, perr_c, ferr_c, ovr_c, brk_c, busy_c;
    logic [6:0] data_c;

    int n_vec = 0;
    int n_err = 0;
    int dvc_a = 0, ovrc_a = 0, brkc_a = 0, dvc_c = 0;
    int s_dv, s_ovr, s_brk;

    always #5 clk = ~clk;

    uart_rx_cfg dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .i_Rx_Ready(rdy_a),
        .o_Rx_DV(dv_a), .o_Rx_Data(data_a), .o_Parity_Err(perr_a), .o_Framing_Err(ferr_a),
        .o_Overrun(ovr_a), .o_Break(brk_a), .o_Busy(busy_a)
    );

    uart_rx_cfg #(.CLK_FREQ_HZ(1_843_200), .BAUDRATE(115_200), .PARITY(2)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .i_Rx_Ready(1'b1),
        .o_Rx_DV(dv_b), .o_Rx_Data(data_b), .o_Parity_Err(perr_b), .o_Framing_Err(ferr_b),
        .o_Overrun(ovr_b), .o_Break(brk_b), .o_Busy(busy_b)
    );

    uart_rx_cfg #(.CLK_FREQ_HZ(1_843_200), .BAUDRATE(115_200), .DATA_BITS(7), .STOP_BITS(2)) dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c), .i_Rx_Ready(1'b1),
        .o_Rx_DV(dv_c), .o_Rx_Data(data_c), .o_Parity_Err(perr_c), .o_Framing_Err(ferr_c),
        .o_Overrun(ovr_c), .o_Break(brk_c), .o_Busy(busy_c)
    );

    // Pulse/level counters sampled away from the active edge.
    always @(negedge clk) begin
        if (dv_a)  dvc_a  <= dvc_a + 1;
        if (ovr_a) ovrc_a <= ovrc_a + 1;
        if (brk_a) brkc_a <= brkc_a + 1;
        if (dv_c)  dvc_c  <= dvc_c + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int u, input logic v);
        case (u)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Drive n line bits LSB first, each held for cpb clocks.
    task automatic send_bits(input int u, input logic [15:0] bits, input int n, input int cpb);
        for (int i = 0; i < n; i++) begin
            set_line(u, bits[i]);
            repeat (cpb) @(negedge clk);
        end
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_dv", {31'd0, dv_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_data", {24'd0, data_a}, 32'd0);
        chk("rst_flags", {28'd0, perr_a, ferr_a, ovr_a, brk_a}, 32'd0);

        // 8N1 0xA5 with ready tied high.
        s_dv = dvc_a;
        send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, CPA);
        chk("t1_dv_cycles", 32'(dvc_a - s_dv), 32'd1);
        chk("t1_data", {24'd0, data_a}, 32'hA5);
        chk("t1_errs", {30'd0, perr_a, ferr_a}, 32'd0);
        chk("t1_busy", {31'd0, busy_a}, 32'd0);

        // Even parity: 0x07 needs parity bit 1.
        send_bits(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, CPS);
        repeat (2 * CPS) @(negedge clk);
        chk("t2_bad_data", {24'd0, data_b}, 32'h07);
        chk("t2_bad_perr", {31'd0, perr_b}, 32'd1);
        send_bits(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, CPS);
        repeat (2 * CPS) @(negedge clk);
        chk("t2_good_perr", {31'd0, perr_b}, 32'd0);
        chk("t2_good_ferr", {31'd0, ferr_b}, 32'd0);

        // Stop bit low long enough to be sampled, then back high.
        send_bits(0, {7'b0, 8'h3C, 1'b0}, 9, CPA);
        rx_a = 1'b0;
        repeat (CPA / 2 + 40) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * CPA) @(negedge clk);
        chk("t3_frm_data", {24'd0, data_a}, 32'h3C);
        chk("t3_frm_ferr", {31'd0, ferr_a}, 32'd1);
        s_dv = dvc_a;
        s_brk = brkc_a;
        rx_a = 1'b0;
        repeat (20 * CPA) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * CPA) @(negedge clk);
        chk("t3_brk_pulses", 32'(brkc_a - s_brk), 32'd1);
        chk("t3_brk_no_dv", 32'(dvc_a - s_dv), 32'd0);
        chk("t3_brk_busy", {31'd0, busy_a}, 32'd0);
        send_bits(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, CPA);
        chk("t3_after_data", {24'd0, data_a}, 32'h55);
        chk("t3_after_errs", {30'd0, perr_a, ferr_a}, 32'd0);

        // Stalled consumer: second frame overruns.
        rdy_a = 1'b0;
        s_ovr = ovrc_a;
        send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, CPA);
        send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, CPA);
        repeat (CPA) @(negedge clk);
        chk("t4_held_dv", {31'd0, dv_a}, 32'd1);
        chk("t4_held_data", {24'd0, data_a}, 32'h11);
        chk("t4_ovr_pulses", 32'(ovrc_a - s_ovr), 32'd1);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        chk("t4_accept_dv", {31'd0, dv_a}, 32'd0);
        chk("t4_accept_data", {24'd0, data_a}, 32'h11);
        rdy_a = 1'b1;

        // Short low pulse is rejected at the start-bit centre.
        s_dv = dvc_a;
        rx_a = 1'b0;
        repeat (50) @(negedge clk);
        chk("t5_glitch_busy_hi", {31'd0, busy_a}, 32'd1);
        repeat (50) @(negedge clk);
        rx_a = 1'b1;
        repeat (300) @(negedge clk);
        chk("t5_glitch_busy_lo", {31'd0, busy_a}, 32'd0);
        chk("t5_glitch_no_dv", 32'(dvc_a - s_dv), 32'd0);

        // 0xFF with a one-clock low spike in the middle of data bit 2.
        send_bits(0, 16'h0006, 3, CPA);
        rx_a = 1'b1;
        repeat (CPA / 2) @(negedge clk);
        rx_a = 1'b0;
        @(negedge clk);
        rx_a = 1'b1;
        repeat (CPA / 2 - 1) @(negedge clk);
        send_bits(0, 16'h003F, 6, CPA);
        chk("t5_spike_data", {24'd0, data_a}, 32'hFF);
        chk("t5_spike_dv", 32'(dvc_a - s_dv), 32'd1);

        // 7 data bits, 2 stop bits; reset in the middle of a frame.
        send_bits(2, {6'b0, 2'b11, 7'h33, 1'b0}, 10, CPS);
        repeat (2 * CPS) @(negedge clk);
        chk("t6_first_data", {25'd0, data_c}, 32'h33);
        s_dv = dvc_c;
        send_bits(2, {6'b0, 2'b11, 7'h6B, 1'b0}, 5, CPS);
        rx_c = 1'b0;
        repeat (CPS / 2) @(negedge clk);
        rst = 1'b1;
        #2;
        chk("t6_rst_outs", {24'd0, dv_c, perr_c, ferr_c, ovr_c, brk_c, busy_c, 2'b00}, 32'd0);
        chk("t6_rst_data", {25'd0, data_c}, 32'd0);
        rx_c = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPS) @(negedge clk);
        chk("t6_abort_no_dv", 32'(dvc_c - s_dv), 32'd0);
        send_bits(2, {6'b0, 2'b11, 7'h5A, 1'b0}, 10, CPS);
        repeat (2 * CPS) @(negedge clk);
        chk("t6_data", {25'd0, data_c}, 32'h5A);
        chk("t6_errs", {30'd0, perr_c, ferr_c}, 32'd0);
        chk("t6_dv", 32'(dvc_c - s_dv), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
